// File: rtl/vendor_change_dispenser.sv
// vendor_change_dispenser
//   Pays a change amount back out as coins, largest denomination first, through
//   a coin_valid/coin_ack handshake to the coin hopper. Keeps a per-denomination
//   inventory, reports unpaid remainder (short/shortfall) and flags a hopper
//   that never acknowledges (sticky fault).
//
//   Denomination code (coin_out, refill_coin): 0=10, 1=20, 3=50, 2=100.
//
//   Optional build macro: CHANGE_EXACT_ONLY_EN
//     When defined, a CHECK phase first simulates the greedy payout on shadow
//     copies; if it cannot reach zero, nothing is ejected and the whole amount
//     is reported as shortfall.
//
//   Ports
//     clk, reset_n                 clock (rising edge), async active-low reset
//     change_req, change_amount    request a payout (accepted when idle, no fault)
//     coin_out, coin_valid, coin_ack   eject handshake to the hopper
//     refill, refill_coin, refill_count  inventory add (idle only, saturating)
//     fault_clr                    clears fault (idle only)
//     busy, done, short, shortfall, fault   status

module vendor_change_dispenser #(
    parameter int AMT_W       = 11,
    parameter int INV_W       = 8,
    parameter int INV_INIT    = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             change_req,
    input  logic [AMT_W-1:0] change_amount,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             refill,
    input  logic [1:0]       refill_coin,
    input  logic [INV_W-1:0] refill_count,
    input  logic             fault_clr,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] shortfall,
    output logic             fault
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AMT_W-1:0] V10  = AMT_W'(10);
    localparam logic [AMT_W-1:0] V20  = AMT_W'(20);
    localparam logic [AMT_W-1:0] V50  = AMT_W'(50);
    localparam logic [AMT_W-1:0] V100 = AMT_W'(100);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE
`ifdef CHANGE_EXACT_ONLY_EN
        , S_CHECK
`endif
    } state_t;

    function automatic logic [AMT_W-1:0] f_value(input logic [1:0] code);
        case (code)
            2'd0:    return V10;
            2'd1:    return V20;
            2'd2:    return V100;
            default: return V50;
        endcase
    endfunction

    // Returns {found, code}; later tests override earlier ones, so the
    // largest eligible denomination wins.
    function automatic logic [2:0] f_pick(input logic [AMT_W-1:0] rem, input logic [3:0] avail);
        logic [2:0] pick;
        pick = 3'b000;
        if (avail[0] && rem >= V10)  pick = 3'b100;
        if (avail[1] && rem >= V20)  pick = 3'b101;
        if (avail[3] && rem >= V50)  pick = 3'b111;
        if (avail[2] && rem >= V100) pick = 3'b110;
        return pick;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AMT_W-1:0]   r_remaining;
    logic [INV_W-1:0]   r_inv [4];
    logic [TMO_W-1:0]   r_tmo;
    logic [1:0]         r_coin_out;
    logic               r_short;
    logic [AMT_W-1:0]   r_shortfall;
    logic               r_fault;

    logic [3:0]         w_avail;
    logic [2:0]         w_pick;
    logic               w_accept;
    logic               w_tmo_hit;
    logic [INV_W:0]     w_refill_sum;
    logic [INV_W-1:0]   w_refill_val;

`ifdef CHANGE_EXACT_ONLY_EN
    logic [AMT_W-1:0]   r_chk_rem;
    logic [INV_W-1:0]   r_chk_inv [4];
    logic [3:0]         w_chk_avail;
    logic [2:0]         w_chk_pick;
`endif

    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            w_avail[c] = (r_inv[c] != '0);
        end
    end

    assign w_pick       = f_pick(r_remaining, w_avail);
    assign w_accept     = (r_state == S_IDLE) && change_req && !r_fault;
    assign w_tmo_hit    = (r_state == S_EJECT) && !coin_ack && (r_tmo == TMO_W'(ACK_TIMEOUT - 1));
    assign w_refill_sum = {1'b0, r_inv[refill_coin]} + {1'b0, refill_count};
    assign w_refill_val = w_refill_sum[INV_W] ? '1 : w_refill_sum[INV_W-1:0];

`ifdef CHANGE_EXACT_ONLY_EN
    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            w_chk_avail[c] = (r_chk_inv[c] != '0);
        end
    end
    assign w_chk_pick = f_pick(r_chk_rem, w_chk_avail);
`endif

    assign coin_out   = r_coin_out;
    assign coin_valid = (r_state == S_EJECT);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign short      = r_short;
    assign shortfall  = r_shortfall;
    assign fault      = r_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef CHANGE_EXACT_ONLY_EN
                if (w_accept) w_state_nxt = S_CHECK;
`else
                if (w_accept) w_state_nxt = S_SELECT;
`endif
            end
            S_SELECT: begin
                if (r_remaining == '0) w_state_nxt = S_DONE;
                else if (w_pick[2])    w_state_nxt = S_EJECT;
                else                   w_state_nxt = S_DONE;
            end
            S_EJECT: begin
                if (coin_ack)       w_state_nxt = S_SELECT;
                else if (w_tmo_hit) w_state_nxt = S_DONE;
            end
`ifdef CHANGE_EXACT_ONLY_EN
            S_CHECK: begin
                if (r_chk_rem == '0)    w_state_nxt = S_SELECT;
                else if (!w_chk_pick[2]) w_state_nxt = S_DONE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
            r_tmo       <= '0;
            r_coin_out  <= '0;
            r_short     <= 1'b0;
            r_shortfall <= '0;
            r_fault     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_inv[i] <= INV_W'(INV_INIT);
            end
`ifdef CHANGE_EXACT_ONLY_EN
            r_chk_rem <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_chk_inv[i] <= '0;
            end
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (refill) r_inv[refill_coin] <= w_refill_val;
                    if (fault_clr) r_fault <= 1'b0;
                    if (w_accept) begin
                        r_remaining <= change_amount;
                        r_short     <= 1'b0;
                        r_shortfall <= '0;
`ifdef CHANGE_EXACT_ONLY_EN
                        // Shadow copy must include a same-cycle refill.
                        r_chk_rem <= change_amount;
                        for (int unsigned i = 0; i < 4; i++) begin
                            r_chk_inv[i] <= (refill && (refill_coin == 2'(i))) ? w_refill_val : r_inv[i];
                        end
`endif
                    end
                end
                S_SELECT: begin
                    if (r_remaining == '0) begin
                        r_short     <= 1'b0;
                        r_shortfall <= '0;
                    end else if (w_pick[2]) begin
                        r_coin_out <= w_pick[1:0];
                        r_tmo      <= '0;
                    end else begin
                        r_short     <= 1'b1;
                        r_shortfall <= r_remaining;
                    end
                end
                S_EJECT: begin
                    if (coin_ack) begin
                        r_remaining       <= r_remaining - f_value(r_coin_out);
                        r_inv[r_coin_out] <= r_inv[r_coin_out] - 1'b1;
                    end else if (w_tmo_hit) begin
                        r_fault     <= 1'b1;
                        r_short     <= 1'b1;
                        r_shortfall <= r_remaining;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
`ifdef CHANGE_EXACT_ONLY_EN
                S_CHECK: begin
                    if (r_chk_rem != '0) begin
                        if (w_chk_pick[2]) begin
                            r_chk_rem                   <= r_chk_rem - f_value(w_chk_pick[1:0]);
                            r_chk_inv[w_chk_pick[1:0]]  <= r_chk_inv[w_chk_pick[1:0]] - 1'b1;
                        end else begin
                            // r_remaining still holds the full requested amount here.
                            r_short     <= 1'b1;
                            r_shortfall <= r_remaining;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vendor_change_dispenser.sv
module tb_vendor_change_dispenser;

    localparam int AMT_W       = 11;
    localparam int INV_W       = 8;
    localparam int ACK_TIMEOUT = 255;

`ifdef CHANGE_EXACT_ONLY_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             change_req;
    logic [AMT_W-1:0] change_amount;
    logic [1:0]       coin_out;
    logic             coin_valid;
    logic             coin_ack;
    logic             refill;
    logic [1:0]       refill_coin;
    logic [INV_W-1:0] refill_count;
    logic             fault_clr;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] shortfall;
    logic             fault;

    int n_checks = 0;
    int n_errors = 0;

    vendor_change_dispenser #(
        .AMT_W(AMT_W), .INV_W(INV_W), .INV_INIT(8), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .change_req(change_req), .change_amount(change_amount),
        .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
        .refill(refill), .refill_coin(refill_coin), .refill_count(refill_count),
        .fault_clr(fault_clr), .busy(busy), .done(done), .short(short),
        .shortfall(shortfall), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Coin list in payout order, first coin in the low bits.
    function automatic logic [7:0] seq(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c, input logic [1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk_inv(input string tag, input int c0, input int c1, input int c2, input int c3);
        chk({tag, "_inv10"},  32'(dut.r_inv[0]), 32'(c0));
        chk({tag, "_inv20"},  32'(dut.r_inv[1]), 32'(c1));
        chk({tag, "_inv100"}, 32'(dut.r_inv[2]), 32'(c2));
        chk({tag, "_inv50"},  32'(dut.r_inv[3]), 32'(c3));
    endtask

    // Issue one request and follow it to done. With ack_en the hopper acks in
    // the first valid cycle; without it, valid must stay up for ACK_TIMEOUT cycles.
    task automatic run_pay(input string tag, input int unsigned amount, input bit ack_en,
                           input int unsigned ncoin, input logic [7:0] codes,
                           input bit exp_short, input int unsigned exp_sf, input bit refill_mid);
        logic [1:0]  got [8];
        logic [7:0]  exp_codes;
        int unsigned ngot;
        int unsigned vcyc;
        bit          prev_v;
        bit          seen_done;
        exp_codes = codes;
        ngot = 0; vcyc = 0; prev_v = 1'b0; seen_done = 1'b0;
        change_amount = AMT_W'(amount);
        change_req = 1'b1;
        tick();
        change_req = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            refill = refill_mid && (cyc == 0);
            if (coin_valid) begin
                vcyc++;
                if (!prev_v) begin
                    if (ngot < 8) got[ngot] = coin_out;
                    ngot++;
                end
            end
            prev_v = coin_valid;
            coin_ack = ack_en && coin_valid;
            if (done) seen_done = 1'b1;
            else tick();
        end
        refill = 1'b0;
        coin_ack = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_ncoins"}, ngot, ncoin);
        for (int unsigned k = 0; k < ncoin && k < 4 && k < ngot; k++) begin
            chk($sformatf("%s_coin%0d", tag, k), 32'(got[k]), 32'(exp_codes[2*k +: 2]));
        end
        chk({tag, "_valid_cycles"}, vcyc, ack_en ? ncoin : 32'(ACK_TIMEOUT));
        chk({tag, "_short"}, 32'(short), 32'(exp_short));
        chk({tag, "_shortfall"}, 32'(shortfall), exp_sf);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        chk({tag, "_sf_hold"}, 32'(shortfall), exp_sf);
    endtask

    initial begin
        int unsigned rises;
        bit          prev_v;

        reset_n = 1'b0; change_req = 1'b0; change_amount = '0; coin_ack = 1'b0;
        refill = 1'b0; refill_coin = '0; refill_count = '0; fault_clr = 1'b0;
        #12;
        chk("rst_valid", 32'(coin_valid), 32'd0);
        chk("rst_coin", 32'(coin_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_short", 32'(short), 32'd0);
        chk("rst_sf", 32'(shortfall), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk_inv("rst", 8, 8, 8, 8);
        reset_n = 1'b1;
        tick();

        // 180 = 100 + 50 + 20 + 10
        run_pay("p180", 180, 1'b1, 4, seq(2, 3, 1, 0), 1'b0, 0, 1'b0);
        chk_inv("p180", 7, 7, 7, 7);

        // 35: greedy leaves 5 unpaid; exact-only refuses outright
        if (EXACT) begin
            run_pay("p35", 35, 1'b1, 0, seq(0, 0, 0, 0), 1'b1, 35, 1'b0);
            chk_inv("p35", 7, 7, 7, 7);
        end else begin
            run_pay("p35", 35, 1'b1, 2, seq(1, 0, 0, 0), 1'b1, 5, 1'b0);
            chk_inv("p35", 6, 6, 7, 7);
        end

        run_pay("p0", 0, 1'b1, 0, seq(0, 0, 0, 0), 1'b0, 0, 1'b0);

        // Empty the 100 tube, then 100 must come out as two 50s
        for (int k = 0; k < 7; k++) begin
            run_pay($sformatf("drain100_%0d", k), 100, 1'b1, 1, seq(2, 0, 0, 0), 1'b0, 0, 1'b0);
        end
        run_pay("p100_2x50", 100, 1'b1, 2, seq(3, 3, 0, 0), 1'b0, 0, 1'b0);
        chk("inv50_after_2x50", 32'(dut.r_inv[3]), 32'd5);

        // Refill and request in the same idle cycle: the new 100 is usable
        refill = 1'b1; refill_coin = 2'd2; refill_count = 8'd1;
        run_pay("refill_same", 100, 1'b1, 1, seq(2, 0, 0, 0), 1'b0, 0, 1'b0);
        chk("inv100_after_same", 32'(dut.r_inv[2]), 32'd0);

        // Saturating refill
        refill = 1'b1; refill_coin = 2'd2; refill_count = 8'd250;
        tick();
        refill_count = 8'd10;
        tick();
        refill = 1'b0;
        chk("inv100_sat", 32'(dut.r_inv[2]), 32'd255);

        // Refill while busy is ignored
        refill_coin = 2'd0; refill_count = 8'd5;
        run_pay("refill_busy", 50, 1'b1, 1, seq(3, 0, 0, 0), 1'b0, 0, 1'b1);
        chk("inv10_unchanged", 32'(dut.r_inv[0]), EXACT ? 32'd7 : 32'd6);
        chk("inv50_after_busy", 32'(dut.r_inv[3]), 32'd4);

        // Below the smallest coin
        run_pay("p7", 7, 1'b1, 0, seq(0, 0, 0, 0), 1'b1, 7, 1'b0);

        // Stuck ejector; fault_clr held throughout must not mask the timeout
        fault_clr = 1'b1;
        run_pay("stuck", 50, 1'b0, 1, seq(3, 0, 0, 0), 1'b1, 50, 1'b0);
        fault_clr = 1'b0;
        chk("stuck_fault", 32'(fault), 32'd1);
        chk("stuck_inv50", 32'(dut.r_inv[3]), 32'd4);
        change_amount = AMT_W'(10);
        change_req = 1'b1;
        tick();
        change_req = 1'b0;
        chk("req_ignored_busy", 32'(busy), 32'd0);
        tick();
        chk("req_ignored_valid", 32'(coin_valid), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_cleared", 32'(fault), 32'd0);

        // Reset during the second coin of a 180 payout
        change_amount = AMT_W'(180);
        change_req = 1'b1;
        tick();
        change_req = 1'b0;
        rises = 0; prev_v = 1'b0;
        for (int cyc = 0; cyc < 100 && rises < 2; cyc++) begin
            if (coin_valid && !prev_v) rises++;
            prev_v = coin_valid;
            if (rises < 2) begin
                coin_ack = coin_valid;
                tick();
            end
        end
        coin_ack = 1'b0;
        chk("mid_second_coin", rises, 2);
        chk("mid_coin_code", 32'(coin_out), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(coin_valid), 32'd0);
        chk("mid_rst_coin", 32'(coin_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);
        chk_inv("mid_rst", 8, 8, 8, 8);
        #10;
        reset_n = 1'b1;
        tick();
        run_pay("post_rst", 10, 1'b1, 1, seq(0, 0, 0, 0), 1'b0, 0, 1'b0);

        // Empty the 10 and 20 tubes, then ask for 60
        for (int k = 0; k < 7; k++) begin
            run_pay($sformatf("drain10_%0d", k), 10, 1'b1, 1, seq(0, 0, 0, 0), 1'b0, 0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            run_pay($sformatf("drain20_%0d", k), 20, 1'b1, 1, seq(1, 0, 0, 0), 1'b0, 0, 1'b0);
        end
        if (EXACT) begin
            run_pay("p60", 60, 1'b1, 0, seq(0, 0, 0, 0), 1'b1, 60, 1'b0);
            chk("p60_inv50", 32'(dut.r_inv[3]), 32'd8);
        end else begin
            run_pay("p60", 60, 1'b1, 1, seq(3, 0, 0, 0), 1'b1, 10, 1'b0);
            chk("p60_inv50", 32'(dut.r_inv[3]), 32'd7);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
